// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Consumed by hazard_ctrl and hazard_sat_cnt.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } hz_state_t;

    localparam int HZ_REG_AW = 4;
    localparam int HZ_CNT_W  = 16;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hazard_sat_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int W = HZ_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes and HALT drain.
// Optional performance counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = HZ_REG_AW,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_halt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    output logic              StopPC,
    output logic              Halt,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble
`ifdef HAZARD_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [HZ_CNT_W-1:0] stall_cnt,
    output logic [HZ_CNT_W-1:0] flush_cnt
`endif
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_t      r_state;
    logic [DCW-1:0] r_drain_cnt;

    logic w_branch;
    logic w_load_use;
    logic w_halt_req;
    logic w_stop;
    logic w_hold;
    logic w_flush;
    logic w_bubble;

    assign w_branch   = ex_valid & ex_branch_taken;
    assign w_load_use = id_valid & ex_valid & ex_mem_read &
                        ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    assign w_halt_req = id_valid & id_halt;

    // Branch outranks load-use, which outranks HALT; a taken branch lets the PC move.
    always_comb begin
        w_stop   = 1'b0;
        w_hold   = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_branch) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_load_use || w_halt_req) begin
                    w_stop   = 1'b1;
                    w_hold   = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_stop   = 1'b1;
                w_hold   = 1'b1;
                w_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_branch && !w_load_use && w_halt_req) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign StopPC      = w_stop;
    assign ifid_hold   = w_hold;
    assign ifid_flush  = w_flush;
    assign idex_bubble = w_bubble;
    assign Halt        = (r_state == ST_HALTED);

`ifdef HAZARD_STATS_EN
    logic w_stall_inc;

    // Stalls while parked in HALTED are not counted.
    assign w_stall_inc = w_stop & (r_state != ST_HALTED);

    hazard_sat_cnt #(.W(HZ_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall_inc),
        .i_clr   (stat_clr),
        .o_count (stall_cnt)
    );

    hazard_sat_cnt #(.W(HZ_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush),
        .i_clr   (stat_clr),
        .o_count (flush_cnt)
    );
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit 5-stage datapath: the producer side of the PC stall/halt interface. It watches the ID and EX stages and drives `StopPC` and `Halt` into the PC register, plus hold/flush/bubble controls into the IF/ID and ID/EX pipeline registers. It resolves load-use stalls, taken-branch flushes and the halt-instruction drain sequence with a small FSM.

## Interface
- `REG_AW`, 4: register-address width (16 architectural registers).
- `DRAIN_CYCLES`, 3: bubbles issued after a halt before `Halt` asserts (EX, MEM, WB drain).
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs`, `id_rt` in REG_AW: ID source registers.
- `id_uses_rs`, `id_uses_rt` in 1: source actually read.
- `id_halt` in 1: ID instruction is HALT (qualified by `id_valid`).
- `ex_valid` in 1: EX stage holds a real instruction.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_rd` in REG_AW: EX destination register.
- `ex_branch_taken` in 1: EX resolved a taken branch/jump this cycle.
- `StopPC` out 1: PC holds its previous value.
- `Halt` out 1: processor halted; PC frozen until reset.
- `ifid_hold` out 1: IF/ID keeps its contents.
- `ifid_flush` out 1: IF/ID loads a NOP (valid=0).
- `idex_bubble` out 1: ID/EX loads a NOP instead of the ID instruction.
- `stall_cnt`, `flush_cnt` out 16: performance counters (only with `HAZARD_STATS_EN`).
- `stat_clr` in 1: clears counters (only with `HAZARD_STATS_EN`).

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset: RUN, drain counter 0, all outputs 0, counters 0.
- RUN, evaluated combinationally in priority order:
  - Branch: `ex_valid & ex_branch_taken` -> `ifid_flush=1`, `idex_bubble=1`, `StopPC=0` (PC takes target). Squashes any hazard/halt in ID. Stay RUN.
  - Load-use: `id_valid & ex_valid & ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))` -> `StopPC=1`, `ifid_hold=1`, `idex_bubble=1` for exactly that cycle. No state change; next cycle EX holds the bubble so the condition clears. Register 0 is not special-cased.
  - Halt: `id_valid & id_halt` -> `StopPC=1`, `ifid_hold=1`, `idex_bubble=1`; load counter with `DRAIN_CYCLES-1`; go DRAIN.
  - Otherwise all outputs 0.
- DRAIN: `StopPC`, `ifid_hold`, `idex_bubble` = 1; counter decrements; when counter==0 go HALTED. Branch/load inputs ignored (EX holds bubbles only).
- HALTED: `Halt=1`, `StopPC=1`, `ifid_hold=1`, `idex_bubble=1`; exit only by `rst`.
- `rst` overrides in any state, including mid-DRAIN: next cycle RUN, outputs 0.

## Timing
- `StopPC`, `ifid_hold`, `ifid_flush`, `idex_bubble` are combinational from state and inputs, same cycle as the detected hazard; consumed by the PC and pipeline registers at the next rising edge.
- `Halt` is a decode of registered state: first asserted `DRAIN_CYCLES+1` edges after the edge where a HALT was presented in ID in RUN (HALT seen cycle 0, DRAIN cycles 1-3, `Halt` high from cycle 4 with default).
- Load-use costs one cycle; taken branch costs one flushed slot (IF/ID) plus one bubble (ID/EX).
- Branch and load-use same cycle: branch only, `StopPC=0`. Branch and halt same cycle: branch only, stay RUN.

## Configuration
- `HAZARD_STATS_EN`: when defined, `stall_cnt` increments on every cycle with `StopPC=1` in RUN or DRAIN, `flush_cnt` on every cycle with `ifid_flush=1`; both saturate at 0xFFFF; `stat_clr` (synchronous) zeroes both, with priority over increment; `rst` zeroes both. When undefined, ports `stall_cnt`, `flush_cnt`, `stat_clr` and their logic are absent.

## Structure
- Shared package: FSM state enum (RUN, DRAIN, HALTED), `REG_AW` default, 16-bit counter width constant.
- Sub-module `hazard_sat_cnt` (16-bit saturating counter with inc/clr), instantiated twice under `HAZARD_STATS_EN`.

## Test plan
- Load r3 in EX, ID reads rs=3 `id_uses_rs=1` -> one cycle `StopPC=ifid_hold=idex_bubble=1`; next cycle (EX bubble) all 0.
- Load r3 in EX, ID reads rt=3 with `id_uses_rt=0` -> no stall, all outputs 0.
- Taken branch in EX plus load-use in ID same cycle -> `ifid_flush=1`, `idex_bubble=1`, `StopPC=0`, `ifid_hold=0`.
- HALT in ID at cycle 0 -> `StopPC=1` cycles 0-3, `Halt=0` cycles 0-3, `Halt=1` cycle 4 onward; stays high for 20 idle cycles.
- `rst` asserted in cycle 2 of DRAIN -> next cycle state RUN, `StopPC=Halt=0`; fresh HALT re-runs the full 3-cycle drain.
- With `HAZARD_STATS_EN`: 3 load-use stalls + 2 branches -> `stall_cnt=3`, `flush_cnt=2`; `stat_clr` -> both 0 next cycle; forced 0xFFFF stall count stays 0xFFFF on further stalls.
